div_rem32: RTL
==============

Name: div_rem32

Overview:
- Iterative restoring divider/remainder unit. It is the inverse-direction companion to the team's combinational 32-bit adder/subtractor.
- Performs one trial subtraction per clock and produces quotient and remainder for the M-extension DIV/DIVU/REM/REMU operations.
- Sits beside the combinational ALU in the execute stage and is driven by a start/done handshake from the control FSM.

Parameters:
- WIDTH, 32, operand/result width in bits. Only 32 is required; the RTL must not hard-code 32 elsewhere.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request pulse; sampled only when busy=0
- sgn  in  1  0 = unsigned (DIVU/REMU), 1 = signed two's complement (DIV/REM); captured with start
- A  in  WIDTH  dividend; captured with start
- B  in  WIDTH  divisor; captured with start
- Q  out  WIDTH  quotient; registered, held until next done
- R  out  WIDTH  remainder; registered, held until next done
- busy  out  1  high while iterating
- done  out  1  one-cycle pulse when Q/R are updated
- div_zero  out  1  registered flag, valid with done: B was 0

Behaviour:
- Reset (async, rst=1): state IDLE; Q=0, R=0, busy=0, done=0, div_zero=0; iteration counter=0. Reset mid-operation aborts the computation and the result is lost.
- States: IDLE, RUN, FIX.
- IDLE:
  - On an edge with start=1, capture |A|, |B|, sgn, sign(A), sign(B), and B==0.
  - Magnitudes are taken only when sgn=1; otherwise operands are used raw.
  - Clear partial remainder (WIDTH+1 bits); counter=0; busy<=1; go to RUN.
- RUN, one step per edge:
  - Shift {rem, dividend} left 1.
  - trial = rem - divisor, computed in WIDTH+1 bits.
  - If trial is non-negative: rem<=trial and the quotient bit is 1. Otherwise rem is unchanged and the quotient bit is 0.
  - After step WIDTH (counter = WIDTH-1), go to FIX.
- FIX, one edge:
  - Apply sign correction: Q is negated if sgn and sign(A)≠sign(B); R is negated if sgn and sign(A)=1.
  - Then apply the divide-by-zero override.
  - Register Q, R, div_zero; busy<=0; done<=1 for exactly this one cycle; go to IDLE.
- Latency: start sampled at edge E0, steps at E1..E32, FIX at E33. done and new Q/R are visible after E33, for 33 cycles total, fixed and data-independent, including divide-by-zero.
- done deasserts on the next edge. Q/R hold until the next FIX.
- busy is high from after E0 through E33 inclusive, then low.
- start while busy=1: ignored. No queueing; A/B/sgn changes have no effect.
- start coincident with done cycle: busy is already 0, so it is accepted and the next operation begins back-to-back.
- Divide by zero (B=0):
  - Q=all ones (0xFFFFFFFF, i.e. -1 signed); R=A as originally presented, signed or not.
  - div_zero=1. The sign correction is overridden.
- Signed overflow (A=0x80000000, B=0xFFFFFFFF, sgn=1): Q=0x80000000, R=0, div_zero=0. This falls out of magnitude arithmetic and needs no special case, but must be checked.
- Identity: for B≠0 and no overflow, A = Q*B + R. |R| < |B|. R carries the sign of A (truncating division).
- All arithmetic is modulo 2^WIDTH except the WIDTH+1-bit trial subtraction. No X may appear on outputs after reset.

Test Plan:
- Unsigned basic: sgn=0, A=100, B=7 -> done exactly 33 cycles after start edge, Q=14, R=2, div_zero=0; busy high 33 cycles.
- Unsigned max: sgn=0, A=0xFFFFFFFF, B=1 -> Q=0xFFFFFFFF, R=0. Then A=5, B=0xFFFFFFFF -> Q=0, R=5.
- Signed signs: sgn=1, (A,B) = (-7,2) -> Q=-3 (0xFFFFFFFD), R=-1. (7,-2) -> Q=-3, R=1. (-7,-2) -> Q=3, R=-1.
- Corners: sgn=1, A=0x80000000, B=0xFFFFFFFF -> Q=0x80000000, R=0. sgn=1, A=-9, B=0 -> Q=0xFFFFFFFF, R=0xFFFFFFF7, div_zero=1, same 33-cycle latency.
- Handshake: assert start with new operands while busy (cycle 10) -> ignored, first result unchanged. Assert start during the done cycle -> accepted, second done 33 cycles later. done is never wider than 1 cycle.
- Reset mid-run: assert rst asynchronously at cycle 15 of a divide -> Q=R=0, busy=done=0 immediately (before next edge). A fresh start after release completes correctly with no done from the aborted operation.

Source files
------------

// File: rtl/div_rem32.sv
// Iterative restoring divider producing quotient and remainder for
// signed and unsigned division, one trial subtraction per clock.
module div_rem32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state, state_nxt;

    // The partial remainder is always below the divisor, so WIDTH bits hold it;
    // the extra bit only exists transiently in the shifted/trial values.
    logic [WIDTH-1:0] rem,   rem_nxt;
    logic [WIDTH-1:0] dvd,   dvd_nxt;
    logic [WIDTH-1:0] dvs,   dvs_nxt;
    logic [WIDTH-1:0] a_raw, a_raw_nxt;
    logic [CW-1:0]    cnt,   cnt_nxt;
    logic             sgn_r, sgn_nxt;
    logic             sa,    sa_nxt;
    logic             sb,    sb_nxt;
    logic             dz,    dz_nxt;

    logic [WIDTH-1:0] q_nxt, r_nxt;
    logic             busy_nxt, done_nxt, div_zero_nxt;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] q_fix, r_fix;

    // State and datapath registers; reset aborts any computation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rem      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            a_raw    <= '0;
            cnt      <= '0;
            sgn_r    <= 1'b0;
            sa       <= 1'b0;
            sb       <= 1'b0;
            dz       <= 1'b0;
            Q        <= '0;
            R        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            state    <= state_nxt;
            rem      <= rem_nxt;
            dvd      <= dvd_nxt;
            dvs      <= dvs_nxt;
            a_raw    <= a_raw_nxt;
            cnt      <= cnt_nxt;
            sgn_r    <= sgn_nxt;
            sa       <= sa_nxt;
            sb       <= sb_nxt;
            dz       <= dz_nxt;
            Q        <= q_nxt;
            R        <= r_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            div_zero <= div_zero_nxt;
        end
    end

    // Next-state, iteration step and result fix-up.
    always_comb begin
        state_nxt    = state;
        rem_nxt      = rem;
        dvd_nxt      = dvd;
        dvs_nxt      = dvs;
        a_raw_nxt    = a_raw;
        cnt_nxt      = cnt;
        sgn_nxt      = sgn_r;
        sa_nxt       = sa;
        sb_nxt       = sb;
        dz_nxt       = dz;
        q_nxt        = Q;
        r_nxt        = R;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        div_zero_nxt = div_zero;

        shifted = {rem, dvd[WIDTH-1]};
        trial   = shifted - {1'b0, dvs};
        q_fix   = (sgn_r && (sa != sb)) ? (~dvd + WIDTH'(1)) : dvd;
        r_fix   = (sgn_r && sa) ? (~rem + WIDTH'(1)) : rem;

        case (state)
            IDLE: begin
                if (start) begin
                    sgn_nxt   = sgn;
                    sa_nxt    = sgn & A[WIDTH-1];
                    sb_nxt    = sgn & B[WIDTH-1];
                    dvd_nxt   = (sgn && A[WIDTH-1]) ? (~A + WIDTH'(1)) : A;
                    dvs_nxt   = (sgn && B[WIDTH-1]) ? (~B + WIDTH'(1)) : B;
                    a_raw_nxt = A;
                    dz_nxt    = (B == '0);
                    rem_nxt   = '0;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // Restoring step: keep the shifted remainder when the trial goes negative.
                rem_nxt = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                dvd_nxt = {dvd[WIDTH-2:0], ~trial[WIDTH]};
                cnt_nxt = cnt + CW'(1);
                if (cnt == CW'(WIDTH - 1)) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                q_nxt        = dz ? '1 : q_fix;
                r_nxt        = dz ? a_raw : r_fix;
                div_zero_nxt = dz;
                busy_nxt     = 1'b0;
                done_nxt     = 1'b1;
                state_nxt    = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
